rvvi_tx_arbiter: RTL and testbench

- Frame-granular arbiter for the 32-bit AXI-stream TX port of the Ethernet MAC FIFO in the hardware RVVI tracer.
- Shares the port between two requesters:
  - Requester 0: the RVVI packetizer (trace frames).
  - Requester 1: the control-frame source (ack and trigger-response frames).
- Never interleaves beats of two frames.
- Enforces a programmable idle gap between frames.
- Provides a starvation guard for the trace stream.

---
 rtl/rvvi_pkg.sv | 22 ++
 rtl/rvvi_axis_mux2.sv | 54 +++++
 rtl/rvvi_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_rvvi_tx_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_pkg.sv
// Shared types for the RVVI TX-port arbiter: arbiter states, requester
// index and the mapping from requester index to one-hot grant.
package rvvi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  // Requester 0 carries trace frames, requester 1 carries control frames.
  typedef enum logic {
    REQ_TRACE = 1'b0,
    REQ_CTRL  = 1'b1
  } req_idx_e;

  function automatic logic [1:0] req_onehot(req_idx_e req);
    return 2'b01 << req;
  endfunction

endpackage

// File: rtl/rvvi_axis_mux2.sv
// Combinational 2:1 AXI-stream forward/ready mux. The one-hot grant selects
// which requester drives the master side; with no grant the master side is
// idle and all outputs are held at zero.
module rvvi_axis_mux2 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]              grant_i,
  input  logic [DATA_WIDTH-1:0]   s0_data_i,
  input  logic [DATA_WIDTH/8-1:0] s0_strb_i,
  input  logic                    s0_last_i,
  input  logic                    s0_valid_i,
  output logic                    s0_ready_o,
  input  logic [DATA_WIDTH-1:0]   s1_data_i,
  input  logic [DATA_WIDTH/8-1:0] s1_strb_i,
  input  logic                    s1_last_i,
  input  logic                    s1_valid_i,
  output logic                    s1_ready_o,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic [DATA_WIDTH/8-1:0] m_strb_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  // Forward the granted requester's beat and route the MAC ready back to it.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned; a missing default here would infer a latch.
    m_data_o   = '0;
    m_strb_o   = '0;
    m_last_o   = 1'b0;
    m_valid_o  = 1'b0;
    s0_ready_o = 1'b0;
    s1_ready_o = 1'b0;
    unique case (grant_i)
      2'b01: begin
        m_data_o   = s0_data_i;
        m_strb_o   = s0_strb_i;
        m_last_o   = s0_last_i;
        m_valid_o  = s0_valid_i;
        s0_ready_o = m_ready_i;
      end
      2'b10: begin
        m_data_o   = s1_data_i;
        m_strb_o   = s1_strb_i;
        m_last_o   = s1_last_i;
        m_valid_o  = s1_valid_i;
        s1_ready_o = m_ready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvvi_tx_arbiter.sv
// Frame-granular arbiter sharing the MAC TX AXI-stream port between the
// RVVI packetizer (requester 0) and the control-frame source (requester 1).
// Ownership is granted for whole frames, an idle gap follows each frame,
// and a starvation guard bounds how many control frames can pass a waiting
// trace frame.
module rvvi_tx_arbiter
  import rvvi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CTRL_BURST_MAX = 4,
  parameter int unsigned GAP_WIDTH      = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   S0Wdata,
  input  logic [DATA_WIDTH/8-1:0] S0Wstrb,
  input  logic                    S0Wlast,
  input  logic                    S0Wvalid,
  output logic                    S0Wready,
  input  logic [DATA_WIDTH-1:0]   S1Wdata,
  input  logic [DATA_WIDTH/8-1:0] S1Wstrb,
  input  logic                    S1Wlast,
  input  logic                    S1Wvalid,
  output logic                    S1Wready,
  output logic [DATA_WIDTH-1:0]   MWdata,
  output logic [DATA_WIDTH/8-1:0] MWstrb,
  output logic                    MWlast,
  output logic                    MWvalid,
  input  logic                    MWready,
  input  logic [GAP_WIDTH-1:0]    GapCycles,
  output logic [1:0]              Grant,
  output logic [CNT_WIDTH-1:0]    Frames0,
  output logic [CNT_WIDTH-1:0]    Frames1
);

  localparam int unsigned STARVE_WIDTH = $clog2(CTRL_BURST_MAX + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(CTRL_BURST_MAX);

  arb_state_e               state_q, state_d;
  logic [GAP_WIDTH-1:0]     gap_q, gap_d;
  logic [STARVE_WIDTH-1:0]  starve_q, starve_d;
  logic [CNT_WIDTH-1:0]     frames0_q, frames0_d;
  logic [CNT_WIDTH-1:0]     frames1_q, frames1_d;
  logic                     beat_done;
  logic                     pick_ctrl;

  assign Frames0 = frames0_q;
  assign Frames1 = frames1_q;

  // A beat moves only when the MAC side handshakes.
  assign beat_done = MWvalid && MWready;

  // Control frames win in IDLE unless the trace stream has already waited
  // through CTRL_BURST_MAX control grants.
  assign pick_ctrl = S1Wvalid && !(S0Wvalid && (starve_q == STARVE_MAX));

  // Grant is a pure decode of the owner states; IDLE and GAP grant nobody.
  always_comb begin
    Grant = 2'b00;
    if (state_q == ST_OWN0) Grant = req_onehot(REQ_TRACE);
    if (state_q == ST_OWN1) Grant = req_onehot(REQ_CTRL);
  end

  rvvi_axis_mux2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .grant_i    (Grant),
    .s0_data_i  (S0Wdata),
    .s0_strb_i  (S0Wstrb),
    .s0_last_i  (S0Wlast),
    .s0_valid_i (S0Wvalid),
    .s0_ready_o (S0Wready),
    .s1_data_i  (S1Wdata),
    .s1_strb_i  (S1Wstrb),
    .s1_last_i  (S1Wlast),
    .s1_valid_i (S1Wvalid),
    .s1_ready_o (S1Wready),
    .m_data_o   (MWdata),
    .m_strb_o   (MWstrb),
    .m_last_o   (MWlast),
    .m_valid_o  (MWvalid),
    .m_ready_i  (MWready)
  );

  // Next-state logic: arbitration, frame completion, gap countdown.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see the
    // defaults; registers below use non-blocking '<=' to avoid update races.
    state_d   = state_q;
    gap_d     = gap_q;
    starve_d  = starve_q;
    frames0_d = frames0_q;
    frames1_d = frames1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_ctrl) begin
          state_d = ST_OWN1;
          if (S0Wvalid && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_WIDTH'(1);
          end
        end else if (S0Wvalid) begin
          state_d  = ST_OWN0;
          starve_d = '0;
        end
      end
      ST_OWN0: begin
        if (beat_done && MWlast) begin
          frames0_d = frames0_q + CNT_WIDTH'(1);
          gap_d     = GapCycles;
          state_d   = (GapCycles != '0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (beat_done && MWlast) begin
          frames1_d = frames1_q + CNT_WIDTH'(1);
          gap_d     = GapCycles;
          state_d   = (GapCycles != '0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_WIDTH'(1);
        if (gap_q <= GAP_WIDTH'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; it only takes effect at the
    // next rising edge, which is what truncates a frame mid-flight.
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      starve_q  <= '0;
      frames0_q <= '0;
      frames1_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      starve_q  <= starve_d;
      frames0_q <= frames0_d;
      frames1_q <= frames1_d;
    end
  end

endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
// Self-checking bench for rvvi_tx_arbiter. Expected M* beats are queued in
// predicted output order when a scenario starts; a monitor pops and compares
// each completed MAC beat. Frame counters use an 8-bit width so the wrap
// scenario fits in a short run.
module tb_rvvi_tx_arbiter;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int GAP_W = 16;
  localparam int CNT_W = 8;
  localparam int BURST = 4;

  typedef struct packed {
    logic [1:0]    grant;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [DW-1:0]    S0Wdata, S1Wdata, MWdata;
  logic [SW-1:0]    S0Wstrb, S1Wstrb, MWstrb;
  logic             S0Wlast, S0Wvalid, S0Wready;
  logic             S1Wlast, S1Wvalid, S1Wready;
  logic             MWlast, MWvalid, MWready;
  logic [GAP_W-1:0] GapCycles;
  logic [1:0]       Grant;
  logic [CNT_W-1:0] Frames0, Frames1;

  beat_t            exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_f0 = '0;
  logic [CNT_W-1:0] exp_f1 = '0;

  rvvi_tx_arbiter #(
    .DATA_WIDTH     (DW),
    .CTRL_BURST_MAX (BURST),
    .GAP_WIDTH      (GAP_W),
    .CNT_WIDTH      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .S0Wdata   (S0Wdata),
    .S0Wstrb   (S0Wstrb),
    .S0Wlast   (S0Wlast),
    .S0Wvalid  (S0Wvalid),
    .S0Wready  (S0Wready),
    .S1Wdata   (S1Wdata),
    .S1Wstrb   (S1Wstrb),
    .S1Wlast   (S1Wlast),
    .S1Wvalid  (S1Wvalid),
    .S1Wready  (S1Wready),
    .MWdata    (MWdata),
    .MWstrb    (MWstrb),
    .MWlast    (MWlast),
    .MWvalid   (MWvalid),
    .MWready   (MWready),
    .GapCycles (GapCycles),
    .Grant     (Grant),
    .Frames0   (Frames0),
    .Frames1   (Frames1)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] beat_data(int req, int fid, int b);
    return DW'((req << 24) | (fid << 12) | b);
  endfunction

  function automatic logic [SW-1:0] beat_strb(int b, int n);
    return (b == n - 1) ? SW'(4'b0111) : SW'(4'b1111);
  endfunction

  // Queue the beats of a frame in the order they must appear on M*.
  function automatic void push_frame(int req, int fid, int n);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.grant = (req == 0) ? 2'b01 : 2'b10;
      e.data  = beat_data(req, fid, b);
      e.strb  = beat_strb(b, n);
      e.last  = (b == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Drive one frame on a requester; starts and returns #1 after a posedge.
  task automatic send_frame(input int req, input int fid, input int n);
    int waited;
    for (int b = 0; b < n; b++) begin
      if (req == 0) begin
        S0Wdata = beat_data(req, fid, b); S0Wstrb = beat_strb(b, n);
        S0Wlast = (b == n - 1);           S0Wvalid = 1'b1;
      end else begin
        S1Wdata = beat_data(req, fid, b); S1Wstrb = beat_strb(b, n);
        S1Wlast = (b == n - 1);           S1Wvalid = 1'b1;
      end
      waited = 0;
      forever begin
        @(negedge clk);
        if (((req == 0) ? S0Wready : S1Wready) === 1'b1) break;
        waited++;
        if (waited > 300) begin
          checks++; errors++;
          $display("FAIL ready_timeout req=%0d frame=%0d beat=%0d waited=%0d required<=300",
                   req, fid, b, waited);
          break;
        end
      end
      @(posedge clk); #1;
    end
    if (req == 0) begin S0Wvalid = 1'b0; S0Wlast = 1'b0; end
    else          begin S1Wvalid = 1'b0; S1Wlast = 1'b0; end
  endtask

  // Scoreboard monitor plus idle-output and hold-stability checks.
  beat_t held;
  logic  held_v = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (MWvalid && MWready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got grant=%b data=%h last=%b required none",
                   Grant, MWdata, MWlast);
        end else begin
          e = exp_q.pop_front();
          if ({Grant, MWdata, MWstrb, MWlast} !== e) begin
            errors++;
            $display("FAIL sb_beat got grant=%b data=%h strb=%b last=%b required grant=%b data=%h strb=%b last=%b",
                     Grant, MWdata, MWstrb, MWlast, e.grant, e.data, e.strb, e.last);
          end
        end
      end
      if (Grant == 2'b00) begin
        checks++;
        if ({MWvalid, S0Wready, S1Wready} !== 3'b000) begin
          errors++;
          $display("FAIL idle_outputs got valid=%b r0=%b r1=%b required 000",
                   MWvalid, S0Wready, S1Wready);
        end
      end
      if (held_v && MWvalid) begin
        checks++;
        if ({Grant, MWdata, MWstrb, MWlast} !== held) begin
          errors++;
          $display("FAIL hold_stable got data=%h last=%b required data=%h last=%b",
                   MWdata, MWlast, held.data, held.last);
        end
      end
      held_v = MWvalid && !MWready;
      held   = {Grant, MWdata, MWstrb, MWlast};
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic test_reset();
    reset = 1'b1; MWready = 1'b1; GapCycles = '0;
    S0Wdata = 32'hDEAD_BEEF; S0Wstrb = '1; S0Wlast = 1'b1; S0Wvalid = 1'b1;
    S1Wdata = '0; S1Wstrb = '0; S1Wlast = 1'b0; S1Wvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({Grant, MWvalid, S0Wready, S1Wready, MWdata, MWstrb, MWlast} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b valid=%b r0=%b r1=%b data=%h strb=%b last=%b required all 0",
               Grant, MWvalid, S0Wready, S1Wready, MWdata, MWstrb, MWlast);
    end
    checks++;
    if (Frames0 !== '0 || Frames1 !== '0) begin
      errors++;
      $display("FAIL reset_frames got f0=%0d f1=%0d required 0 0", Frames0, Frames1);
    end
    S0Wvalid = 1'b0; S0Wlast = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_single_frame();
    push_frame(0, 1, 10);
    exp_f0 = exp_f0 + 1'b1;
    fork
      send_frame(0, 1, 10);
      begin
        @(negedge clk);
        checks++;
        if (Grant !== 2'b00) begin
          errors++; $display("FAIL single_grant_request_cycle got %b required 00", Grant);
        end
        @(negedge clk);
        checks++;
        if (Grant !== 2'b01) begin
          errors++; $display("FAIL single_grant_next_cycle got %b required 01", Grant);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (Grant !== 2'b00 || Frames0 !== exp_f0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_end got grant=%b f0=%0d pending=%0d required 00 %0d 0",
               Grant, Frames0, exp_q.size(), exp_f0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    push_frame(1, 2, 3);
    push_frame(0, 3, 4);
    fork
      send_frame(0, 3, 4);
      send_frame(1, 2, 3);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (Frames1 !== exp_f1) break;
        end
        checks++;
        if (Frames1 !== exp_f1 + 1'b1 || Frames0 !== exp_f0) begin
          errors++;
          $display("FAIL simul_order got f0=%0d f1=%0d required f0=%0d f1=%0d",
                   Frames0, Frames1, exp_f0, exp_f1 + 1'b1);
        end
      end
    join
    exp_f0 = exp_f0 + 1'b1;
    exp_f1 = exp_f1 + 1'b1;
    @(negedge clk);
    checks++;
    if (Frames0 !== exp_f0 || Frames1 !== exp_f1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_end got f0=%0d f1=%0d pending=%0d required %0d %0d 0",
               Frames0, Frames1, exp_q.size(), exp_f0, exp_f1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    for (int k = 0; k < BURST; k++) push_frame(1, 10 + k, 2);
    push_frame(0, 20, 3);
    for (int k = BURST; k < 6; k++) push_frame(1, 10 + k, 2);
    fork
      send_frame(0, 20, 3);
      for (int k = 0; k < 6; k++) send_frame(1, 10 + k, 2);
    join
    exp_f0 = exp_f0 + 1'b1;
    exp_f1 = exp_f1 + 8'd6;
    @(negedge clk);
    checks++;
    if (Frames0 !== exp_f0 || Frames1 !== exp_f1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL starve_end got f0=%0d f1=%0d pending=%0d required %0d %0d 0",
               Frames0, Frames1, exp_q.size(), exp_f0, exp_f1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gap();
    int cnt;
    GapCycles = 16'd3;
    push_frame(0, 30, 4);
    exp_f0 = exp_f0 + 1'b1;
    fork
      send_frame(0, 30, 4);
      begin
        @(negedge clk); @(negedge clk);
        GapCycles = 16'd12;
      end
    join
    push_frame(1, 31, 1);
    exp_f1 = exp_f1 + 1'b1;
    fork
      send_frame(1, 31, 1);
      begin
        GapCycles = '0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (Grant === 2'b10) break;
          cnt++;
        end
        // 12 gap cycles, then one IDLE cycle that samples the waiting request.
        checks++;
        if (cnt != 13) begin
          errors++; $display("FAIL gap_length got %0d required 13", cnt);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (Frames0 !== exp_f0 || Frames1 !== exp_f1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gap_end got f0=%0d f1=%0d pending=%0d required %0d %0d 0",
               Frames0, Frames1, exp_q.size(), exp_f0, exp_f1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int own;
    push_frame(0, 40, 8);
    exp_f0 = exp_f0 + 1'b1;
    own = 0;
    fork
      send_frame(0, 40, 8);
      begin
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
          @(posedge clk); #1 MWready = (i % 2 == 1);
          @(negedge clk);
          if (Grant === 2'b01) own++;
          checks++;
          if (S0Wready !== MWready || S1Wready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready cycle=%0d got r0=%b r1=%b required r0=%b r1=0",
                     i, S0Wready, S1Wready, MWready);
          end
        end
        @(posedge clk); #1 MWready = 1'b1;
      end
    join
    @(negedge clk);
    checks++;
    if (own != 16 || Grant !== 2'b00 || Frames0 !== exp_f0) begin
      errors++;
      $display("FAIL bp_own_cycles got own=%0d grant=%b f0=%0d required 16 00 %0d",
               own, Grant, Frames0, exp_f0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    int done;
    for (int b = 0; b < 3; b++) push_frame_partial(b);
    done = 0;
    S0Wdata = beat_data(0, 50, 0); S0Wstrb = '1; S0Wlast = 1'b0; S0Wvalid = 1'b1;
    for (int i = 0; i < 20 && done < 3; i++) begin
      @(negedge clk);
      if (S0Wready === 1'b1) done++;
      @(posedge clk); #1;
      S0Wdata = beat_data(0, 50, done);
    end
    // Beat 3 is on the bus when reset arrives.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; S0Wvalid = 1'b0;
    exp_f0 = '0; exp_f1 = '0;
    @(negedge clk);
    checks++;
    if (done != 3 || MWvalid !== 1'b0 || Grant !== 2'b00 || Frames0 !== '0 || Frames1 !== '0) begin
      errors++;
      $display("FAIL reset_mid_frame got beats=%0d valid=%b grant=%b f0=%0d f1=%0d required 3 0 00 0 0",
               done, MWvalid, Grant, Frames0, Frames1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL reset_mid_pending got %0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic void push_frame_partial(int b);
    beat_t e;
    e.grant = 2'b01;
    e.data  = beat_data(0, 50, b);
    e.strb  = '1;
    e.last  = 1'b0;
    exp_q.push_back(e);
  endfunction

  task automatic test_wrap();
    for (int i = 0; i < (1 << CNT_W); i++) begin
      push_frame(0, i, 1);
      send_frame(0, i, 1);
      exp_f0 = exp_f0 + 1'b1;
      if (i == (1 << CNT_W) - 2) begin
        checks++;
        if (Frames0 !== exp_f0) begin
          errors++; $display("FAIL wrap_before got %0d required %0d", Frames0, exp_f0);
        end
      end
    end
    checks++;
    if (Frames0 !== exp_f0 || exp_f0 !== '0) begin
      errors++; $display("FAIL wrap_to_zero got %0d required 0", Frames0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_simultaneous();
    test_starvation();
    test_gap();
    test_backpressure();
    test_reset_mid_frame();
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
